// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared FSM encoding and keep-mask helper for the FIFO read packer.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int unsigned MAX_RATIO = 32;

  // Low cnt bits set; saturates to all-ones of the ratio width once cnt >= ratio.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned cnt,
                                                     input int unsigned ratio);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      m[i] = (i < cnt) && (i < ratio);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_packer
// Brief    : Pops DSIZE-bit FIFO entries and packs RATIO of them per output word.
// Revision : 1.0
// ============================================================================
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   flush_done
);

  localparam int OW = DSIZE * RATIO;
  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);
  localparam logic [CW:0]   OCC_FULL = (CW + 1)'(RATIO);

  typedef logic [RATIO-1:0] keep_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          inflight_q;
  logic [OW-1:0] pack_q;
  logic [OW-1:0] out_data_q;
  keep_t         out_keep_q;
  logic          out_valid_q;
  logic          flush_done_q;

  logic          slot_ok;
  logic [CW:0]   occ;
  logic [CW-1:0] cnt_arr;
  logic [OW-1:0] pack_arr;

  assign slot_ok = !out_valid_q || out_ready;
  assign occ     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  // A pop at occ==RATIO is safe only if the word completing this cycle can load now.
  assign rinc = !rrst && !rempty && (state_q == RUN) && !flush &&
                ((occ < OCC_FULL) || ((occ == OCC_FULL) && slot_ok));

  // Pack register as it looks once the returning byte (if any) lands in slot cnt.
  assign cnt_arr = cnt_q + CW'(inflight_q);
  always_comb begin
    pack_arr = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (inflight_q && (cnt_q == CW'(i))) begin
        pack_arr[i*DSIZE +: DSIZE] = rdata;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      pack_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      inflight_q   <= rinc;
      flush_done_q <= 1'b0;
      pack_q       <= pack_arr;
      cnt_q        <= cnt_arr;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        RUN: begin
          if ((cnt_arr == CNT_FULL) && slot_ok) begin
            out_data_q  <= pack_arr;
            out_keep_q  <= '1;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            pack_q      <= '0;
          end
          if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight_q) begin
            if (cnt_q == '0) begin
              state_q      <= RUN;
              flush_done_q <= 1'b1;
            end else begin
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          // Unfilled slots read as zero because pack_q is cleared on every load.
          if (slot_ok) begin
            out_data_q   <= pack_q;
            out_keep_q   <= keep_t'(keep_mask(32'(cnt_q), RATIO));
            out_valid_q  <= 1'b1;
            cnt_q        <= '0;
            pack_q       <= '0;
            flush_done_q <= 1'b1;
            state_q      <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_packer
// Brief    : Self-checking bench for fifo_rd_packer with a queue-based FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_packer;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int OW    = DSIZE * RATIO;

  typedef struct packed {
    logic [OW-1:0]    d;
    logic [RATIO-1:0] k;
  } word_t;

  logic             clk = 1'b0;
  logic             rrst = 1'b1;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rinc;
  logic [OW-1:0]    out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             flush = 1'b0;
  logic             flush_done;

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  logic [DSIZE-1:0] src[$];
  word_t            got[$];
  word_t            exp_q[$];
  bit               hist_rinc[$];
  bit               hist_valid[$];
  bit               hist_fd[$];

  int    pass_cnt = 0;
  int    chk_cnt = 0;
  int    stall_pct = 0;
  bit    rand_ready = 1'b0;
  int    rinc_err = 0;
  int    hold_err = 0;
  bit    prev_hold = 1'b0;
  word_t prev_word;

  logic             s_rinc, s_valid, s_fd;
  logic [OW-1:0]    s_data;
  logic [RATIO-1:0] s_keep;

  // One clock cycle: present FIFO flags, observe at negedge, deliver popped byte after the edge.
  task automatic step();
    bit popped;
    rempty = (src.size() == 0) || (int'($urandom_range(0, 99)) < stall_pct);
    if (rand_ready) out_ready = (int'($urandom_range(0, 99)) < 70);
    @(negedge clk);
    s_rinc = rinc; s_valid = out_valid; s_fd = flush_done;
    s_data = out_data; s_keep = out_keep;
    if (rinc && rempty) rinc_err++;
    if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_word.d || out_keep !== prev_word.k))
      hold_err++;
    prev_hold = out_valid && !out_ready && !rrst;
    prev_word = {out_data, out_keep};
    if (out_valid && out_ready && !rrst) got.push_back({out_data, out_keep});
    hist_rinc.push_back(rinc); hist_valid.push_back(out_valid); hist_fd.push_back(flush_done);
    popped = rinc && !rempty && (src.size() > 0);
    @(posedge clk);
    #1;
    if (popped) rdata = src.pop_front();
    else        rdata = DSIZE'($urandom);
    flush = 1'b0;
  endtask

  task automatic clear_obs();
    got.delete(); hist_rinc.delete(); hist_valid.delete(); hist_fd.delete();
  endtask

  // Reference: bytes of one flushed segment, grouped RATIO per word, trailing partial word.
  function automatic void model_segment(input logic [DSIZE-1:0] seg[$]);
    word_t w;
    for (int i = 0; i < seg.size(); i += RATIO) begin
      w = '0;
      for (int j = 0; j < RATIO && (i + j) < seg.size(); j++) begin
        w.d[j*DSIZE +: DSIZE] = seg[i+j];
        w.k[j] = 1'b1;
      end
      exp_q.push_back(w);
    end
  endfunction

  function automatic int count_ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i]);
    return n;
  endfunction

  task automatic test_reset();
    bit any_rinc = 1'b0;
    rrst = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) src.push_back(DSIZE'(8'hE0 + i));
    for (int i = 0; i < 2; i++) begin step(); any_rinc |= (s_rinc !== 1'b0); end
    chk_cnt++; if (any_rinc !== 1'b0) $display("FAIL reset_rinc: got rinc active, want 0"); else pass_cnt++;
    chk_cnt++; if (s_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_valid); else pass_cnt++;
    chk_cnt++; if (s_keep !== 4'h0) $display("FAIL reset_keep: got %h want 0", s_keep); else pass_cnt++;
    chk_cnt++; if (s_fd !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", s_fd); else pass_cnt++;
    chk_cnt++; if (s_data !== '0) $display("FAIL reset_data: got %h want 0", s_data); else pass_cnt++;
    src.delete(); rrst = 1'b0;
  endtask

  task automatic test_stream();
    int run = 0, best = 0;
    word_t w0, w1;
    clear_obs(); out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) src.push_back(DSIZE'(i));
    for (int i = 0; i < 16; i++) step();
    foreach (hist_rinc[i]) begin
      run = hist_rinc[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
    w0 = (got.size() > 0) ? got[0] : '0;
    w1 = (got.size() > 1) ? got[1] : '0;
    chk_cnt++; if (best != 8 || count_ones(hist_rinc) != 8) $display("FAIL stream_rinc_run: got run %0d pops %0d want 8/8", best, count_ones(hist_rinc)); else pass_cnt++;
    chk_cnt++; if (got.size() != 2) $display("FAIL stream_count: got %0d want 2", got.size()); else pass_cnt++;
    chk_cnt++; if (w0.d !== 32'h04030201) $display("FAIL stream_word0: got %h want 04030201", w0.d); else pass_cnt++;
    chk_cnt++; if (w0.k !== 4'hF) $display("FAIL stream_keep0: got %h want f", w0.k); else pass_cnt++;
    chk_cnt++; if (w1.d !== 32'h08070605) $display("FAIL stream_word1: got %h want 08070605", w1.d); else pass_cnt++;
    chk_cnt++; if (w1.k !== 4'hF) $display("FAIL stream_keep1: got %h want f", w1.k); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int tail = 0;
    clear_obs(); out_ready = 1'b0; hold_err = 0;
    for (int i = 1; i <= 8; i++) src.push_back(DSIZE'(i));
    for (int i = 0; i < 14; i++) step();
    for (int i = 10; i < 14; i++) tail += int'(hist_rinc[i]);
    chk_cnt++; if (count_ones(hist_rinc) != 8 || tail != 0) $display("FAIL bp_pops: got %0d pops (%0d late) want 8 (0 late)", count_ones(hist_rinc), tail); else pass_cnt++;
    chk_cnt++; if (s_valid !== 1'b1 || s_data !== 32'h04030201) $display("FAIL bp_hold: got v=%b %h want v=1 04030201", s_valid, s_data); else pass_cnt++;
    chk_cnt++; if (s_keep !== 4'hF) $display("FAIL bp_keep: got %h want f", s_keep); else pass_cnt++;
    chk_cnt++; if (got.size() != 0 || hold_err != 0) $display("FAIL bp_stable: got %0d accepted, %0d hold errors, want 0/0", got.size(), hold_err); else pass_cnt++;
    out_ready = 1'b1;
    step();
    step();
    chk_cnt++; if (s_valid !== 1'b1 || s_data !== 32'h08070605) $display("FAIL bp_next: got v=%b %h want v=1 08070605", s_valid, s_data); else pass_cnt++;
    step(); step();
    chk_cnt++; if (got.size() != 2 || got[0].d !== 32'h04030201) $display("FAIL bp_order: got %0d words want 2 starting 04030201", got.size()); else pass_cnt++;
  endtask

  task automatic test_flush_partial();
    int guard = 0;
    bit aligned = 1'b0;
    word_t w;
    clear_obs(); out_ready = 1'b1;
    src.push_back(8'hAA); src.push_back(8'hBB);
    while (src.size() > 0 && guard < 10) begin step(); guard++; end
    flush = 1'b1; step();
    for (int i = 0; i < 6; i++) step();
    for (int i = 1; i < hist_fd.size(); i++)
      if (hist_fd[i]) aligned = hist_valid[i] && !hist_valid[i-1];
    w = (got.size() > 0) ? got[0] : '0;
    chk_cnt++; if (got.size() != 1) $display("FAIL fp_count: got %0d want 1", got.size()); else pass_cnt++;
    chk_cnt++; if (w.d !== 32'h0000BBAA) $display("FAIL fp_data: got %h want 0000bbaa", w.d); else pass_cnt++;
    chk_cnt++; if (w.k !== 4'b0011) $display("FAIL fp_keep: got %b want 0011", w.k); else pass_cnt++;
    chk_cnt++; if (count_ones(hist_fd) != 1) $display("FAIL fp_done_count: got %0d want 1", count_ones(hist_fd)); else pass_cnt++;
    chk_cnt++; if (aligned !== 1'b1) $display("FAIL fp_done_align: got %b want 1", aligned); else pass_cnt++;
  endtask

  task automatic test_flush_empty();
    clear_obs(); out_ready = 1'b1;
    flush = 1'b1; step();
    for (int i = 0; i < 5; i++) step();
    chk_cnt++; if (count_ones(hist_fd) != 1) $display("FAIL fe_done: got %0d pulses want 1", count_ones(hist_fd)); else pass_cnt++;
    chk_cnt++; if (count_ones(hist_valid) != 0) $display("FAIL fe_noword: got %0d valid cycles want 0", count_ones(hist_valid)); else pass_cnt++;
  endtask

  task automatic test_flush_after_pop();
    word_t w;
    clear_obs(); out_ready = 1'b1;
    src.push_back(8'h5C);
    step();
    flush = 1'b1; step();
    for (int i = 0; i < 6; i++) step();
    w = (got.size() > 0) ? got[0] : '0;
    chk_cnt++; if (got.size() != 1 || w.d !== 32'h0000005C) $display("FAIL fap_data: got %0d words %h want 1 0000005c", got.size(), w.d); else pass_cnt++;
    chk_cnt++; if (w.k !== 4'b0001) $display("FAIL fap_keep: got %b want 0001", w.k); else pass_cnt++;
    chk_cnt++; if (count_ones(hist_fd) != 1) $display("FAIL fap_done: got %0d want 1", count_ones(hist_fd)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    word_t w;
    clear_obs(); out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) src.push_back(DSIZE'(8'h70 + i));
    while (src.size() > 0 && guard < 20) begin step(); guard++; end
    chk_cnt++; if (s_valid !== 1'b1) $display("FAIL rm_setup_valid: got %b want 1", s_valid); else pass_cnt++;
    src.push_back(8'hF1); src.push_back(8'hF2);
    rrst = 1'b1; step();
    chk_cnt++; if (s_rinc !== 1'b0) $display("FAIL rm_rinc: got %b want 0", s_rinc); else pass_cnt++;
    rrst = 1'b0; src.delete(); step();
    chk_cnt++; if (s_valid !== 1'b0 || s_keep !== 4'h0) $display("FAIL rm_cleared: got v=%b k=%h want 0/0", s_valid, s_keep); else pass_cnt++;
    chk_cnt++; if (s_data !== '0) $display("FAIL rm_data: got %h want 0", s_data); else pass_cnt++;
    got.delete(); out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) src.push_back(DSIZE'(8'h10 + i));
    for (int i = 0; i < 12; i++) step();
    w = (got.size() > 0) ? got[0] : '0;
    chk_cnt++; if (got.size() != 1 || w.d !== 32'h14131211 || w.k !== 4'hF) $display("FAIL rm_after: got %0d words %h/%h want 1 14131211/f", got.size(), w.d, w.k); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DSIZE-1:0] seg[$];
    int timeouts = 0, fd_before, guard, nseg = 8;
    clear_obs(); exp_q.delete();
    rinc_err = 0; hold_err = 0; stall_pct = 30; rand_ready = 1'b1;
    for (int s = 0; s < nseg; s++) begin
      seg.delete();
      for (int i = 0; i < int'($urandom_range(1, 13)); i++) seg.push_back(DSIZE'($urandom));
      foreach (seg[i]) src.push_back(seg[i]);
      model_segment(seg);
      guard = 0;
      while (src.size() > 0 && guard < 500) begin step(); guard++; end
      if (guard >= 500) timeouts++;
      fd_before = count_ones(hist_fd);
      flush = 1'b1; step();
      guard = 0;
      while (count_ones(hist_fd) == fd_before && guard < 100) begin step(); guard++; end
      if (guard >= 100) timeouts++;
    end
    rand_ready = 1'b0; out_ready = 1'b1; stall_pct = 0;
    for (int i = 0; i < 6; i++) step();
    chk_cnt++; if (timeouts != 0) $display("FAIL rnd_timeout: got %0d expired waits want 0", timeouts); else pass_cnt++;
    chk_cnt++; if (got.size() != exp_q.size()) $display("FAIL rnd_count: got %0d words want %0d", got.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk_cnt++;
      if (got[i] !== exp_q[i]) $display("FAIL rnd_word[%0d]: got %h/%h want %h/%h", i, got[i].d, got[i].k, exp_q[i].d, exp_q[i].k);
      else pass_cnt++;
    end
    chk_cnt++; if (count_ones(hist_fd) != nseg) $display("FAIL rnd_done: got %0d pulses want %0d", count_ones(hist_fd), nseg); else pass_cnt++;
    chk_cnt++; if (rinc_err != 0) $display("FAIL rnd_rinc_empty: got %0d pops while empty want 0", rinc_err); else pass_cnt++;
    chk_cnt++; if (hold_err != 0) $display("FAIL rnd_hold: got %0d unstable holds want 0", hold_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_after_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
